// File: rtl/lsu_unit.sv
// Load/store unit: one handshaked access at a time between execute and a word-wide
// data memory, with lane steering, byte enables, load extension, misalign and timeout checks.
module lsu_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk_t,
    input  logic                    rst_t,
    input  logic                    req_valid_t,
    output logic                    req_ready_t,
    input  logic                    req_wr_t,
    input  logic [1:0]              req_size_t,
    input  logic                    req_unsigned_t,
    input  logic [ADDR_WIDTH-1:0]   req_addr_t,
    input  logic [XLEN-1:0]         req_wdata_t,
    output logic                    resp_valid_t,
    output logic [XLEN-1:0]         resp_rdata_t,
    output logic [1:0]              resp_err_t,
    output logic                    mem_req_t,
    output logic                    mem_we_t,
    output logic [ADDR_WIDTH-1:0]   mem_addr_t,
    output logic [XLEN/8-1:0]       mem_be_t,
    output logic [XLEN-1:0]         mem_wdata_t,
    input  logic                    mem_ack_t,
    input  logic [XLEN-1:0]         mem_rdata_t
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [OFF_W-1:0]       off_q, off_d;

    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]        resp_rdata_q, resp_rdata_d;
    logic [1:0]             resp_err_q, resp_err_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [NB-1:0]          mem_be_q, mem_be_d;
    logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;

    logic [OFF_W-1:0]       off_c;
    logic                   illegal_c;
    logic                   misal_c;
    logic [NB-1:0]          be_c;
    logic [XLEN-1:0]        wdata_c;
    logic [XLEN-1:0]        shifted_c;
    logic [XLEN-1:0]        load_c;
    logic                   tout_c;

    // Request decode: lane offset, legality, byte enables and replicated store data
    always_comb begin
        off_c     = req_addr_t[OFF_W-1:0];
        illegal_c = (XLEN == 32) && (req_size_t == 2'b11);
        misal_c   = 1'b0;
        be_c      = '1;
        wdata_c   = req_wdata_t;
        unique case (req_size_t)
            2'b00: begin
                be_c    = NB'(1) << off_c;
                wdata_c = {NB{req_wdata_t[7:0]}};
            end
            2'b01: begin
                misal_c = off_c[0];
                be_c    = NB'(3) << off_c;
                wdata_c = {(NB/2){req_wdata_t[15:0]}};
            end
            2'b10: begin
                misal_c = |off_c[1:0];
                be_c    = NB'(15) << off_c;
                wdata_c = {(XLEN/32){req_wdata_t[31:0]}};
            end
            default: begin
                misal_c = |off_c;
                be_c    = '1;
                wdata_c = req_wdata_t;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the captured size
    always_comb begin
        shifted_c = mem_rdata_t >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   load_c = uns_q ? XLEN'(shifted_c[7:0])  : XLEN'($signed(shifted_c[7:0]));
            2'b01:   load_c = uns_q ? XLEN'(shifted_c[15:0]) : XLEN'($signed(shifted_c[15:0]));
            2'b10:   load_c = uns_q ? XLEN'(shifted_c[31:0]) : XLEN'($signed(shifted_c[31:0]));
            default: load_c = shifted_c;
        endcase
    end

    assign tout_c = (TIMEOUT != 0) && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_ready_q && req_valid_t) begin
                    wr_d   = req_wr_t;
                    size_d = req_size_t;
                    uns_d  = req_unsigned_t;
                    off_d  = off_c;
                    cnt_d  = '0;
                    if (illegal_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_SIZE;
                        resp_rdata_d = '0;
                    end else if (misal_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_ALIGN;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_wr_t;
                        mem_addr_d  = {req_addr_t[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            S_MEM: begin
                // An ack on the timeout cycle still completes the access
                if (mem_ack_t) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = wr_q ? '0 : load_c;
                end else if (tout_c) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TOUT;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready_t  = req_ready_q;
    assign resp_valid_t = resp_valid_q;
    assign resp_rdata_t = resp_rdata_q;
    assign resp_err_t   = resp_err_q;
    assign mem_req_t    = mem_req_q;
    assign mem_we_t     = mem_we_q;
    assign mem_addr_t   = mem_addr_q;
    assign mem_be_t     = mem_be_q;
    assign mem_wdata_t  = mem_wdata_q;

endmodule
